// File: rtl/pattern_beacon_pkg.sv
// Shared types and the per-channel pattern step function for pattern_beacon.
package pattern_beacon_pkg;

  localparam int unsigned MAX_W = 32;

  typedef enum logic [1:0] {
    MODE_INC  = 2'd0,
    MODE_DEC  = 2'd1,
    MODE_LFSR = 2'd2,
    MODE_WALK = 2'd3
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Next pattern value for a w-bit channel; zero escapes to 1 for LFSR/WALK.
  function automatic logic [MAX_W-1:0] next_value(input logic [MAX_W-1:0] v,
                                                  input mode_t             m,
                                                  input int unsigned       w,
                                                  input logic [MAX_W-1:0] taps);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] r;
    mask = MAX_W'((64'd1 << w) - 64'd1);
    r    = v;
    case (m)
      MODE_INC:  r = (v + MAX_W'(1)) & mask;
      MODE_DEC:  r = (v - MAX_W'(1)) & mask;
      MODE_LFSR: r = (v == '0) ? MAX_W'(1) : (((v >> 1) ^ (v[0] ? taps : '0)) & mask);
      MODE_WALK: r = (v == '0) ? MAX_W'(1) : (((v << 1) | (v >> (w - 1))) & mask);
      default:   r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pattern_beacon_timer.sv
// Free-running period counter; tick marks the last cycle of each period while enabled.
module beacon_timer #(
  parameter int unsigned PERIOD = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(PERIOD);

  logic [CNT_W-1:0] cnt_q;
  logic             at_end;

  assign at_end = (cnt_q == CNT_W'(PERIOD - 1));
  assign tick   = en && at_end;

  always_ff @(posedge clk) begin
    if (rst || !en || at_end) cnt_q <= '0;
    else                      cnt_q <= cnt_q + CNT_W'(1);
  end

endmodule

// File: rtl/pattern_beacon.sv
// Periodic multi-channel test-pattern streamer with valid/ready output and overrun counting.
module pattern_beacon
  import pattern_beacon_pkg::*;
#(
  parameter int unsigned           DATA_W    = 8,
  parameter int unsigned           N_CH      = 4,
  parameter int unsigned           PERIOD    = 10000,
  parameter logic [DATA_W-1:0]     LFSR_TAPS = DATA_W'(8'hB8),
  localparam int unsigned          CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic [CH_W-1:0]   tx_chan,
  output logic              frame_done,
  output logic [7:0]        overrun_cnt
);

  logic              tick;
  state_t            state_q,      state_d;
  mode_t             mode_q,       mode_d;
  logic              tx_valid_q,   tx_valid_d;
  logic [DATA_W-1:0] tx_data_q,    tx_data_d;
  logic [CH_W-1:0]   tx_chan_q,    tx_chan_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        overrun_q,    overrun_d;
  logic [DATA_W-1:0] value_q [N_CH];
  logic [DATA_W-1:0] value_d [N_CH];
  logic [DATA_W-1:0] cur_value;
  logic [DATA_W-1:0] nxt_value;

  beacon_timer #(.PERIOD(PERIOD)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // Value of the channel currently on the bus and its successor under the frame's mode.
  always_comb begin
    cur_value = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (CH_W'(k) == tx_chan_q) cur_value = value_q[k];
    end
    nxt_value = DATA_W'(next_value(MAX_W'(cur_value), mode_q, DATA_W, MAX_W'(LFSR_TAPS)));
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    tx_chan_d    = tx_chan_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    value_d      = value_q;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d    = ST_SEND;
          mode_d     = mode_t'(mode);
          tx_chan_d  = '0;
          tx_data_d  = value_q[0];
          tx_valid_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (tick && overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
        if (tx_ready) begin
          for (int k = 0; k < N_CH; k++) begin
            if (CH_W'(k) == tx_chan_q) value_d[k] = nxt_value;
          end
          if (tx_chan_q == CH_W'(N_CH - 1)) begin
            tx_valid_d   = 1'b0;
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
          end else begin
            tx_chan_d = tx_chan_q + CH_W'(1);
            for (int k = 0; k < N_CH; k++) begin
              if (CH_W'(k) == tx_chan_d) tx_data_d = value_q[k];
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset reseeds channel k with k so each channel starts from a distinct value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_INC;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_chan_q    <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= '0;
      for (int k = 0; k < N_CH; k++) value_q[k] <= DATA_W'(k);
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      tx_chan_q    <= tx_chan_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      value_q      <= value_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign tx_chan     = tx_chan_q;
  assign frame_done  = frame_done_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_pattern_beacon.sv
// Directed bench for pattern_beacon: a 4x8 instance and a 1x4 instance on shared inputs.
module tb_pattern_beacon;
  import pattern_beacon_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       tx_ready = 1'b0;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic [1:0] tx_chan;
  logic       frame_done;
  logic [7:0] overrun_cnt;

  logic       b_valid;
  logic [3:0] b_data;
  logic [0:0] b_chan;
  logic       b_done;
  logic [7:0] b_ovr;

  int tests_run = 0;
  int failed = 0;
  logic seen;
  logic [7:0] lfsr_exp [5] = '{8'h00, 8'h01, 8'hB8, 8'h5C, 8'h2E};

  always #5 clk = ~clk;

  pattern_beacon #(.DATA_W(8), .N_CH(4), .PERIOD(16), .LFSR_TAPS(8'hB8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_chan(tx_chan),
    .frame_done(frame_done), .overrun_cnt(overrun_cnt)
  );

  pattern_beacon #(.DATA_W(4), .N_CH(1), .PERIOD(16), .LFSR_TAPS(4'h9)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .tx_ready(tx_ready),
    .tx_valid(b_valid), .tx_data(b_data), .tx_chan(b_chan),
    .frame_done(b_done), .overrun_cnt(b_ovr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench at cycle 0 (timer=0) with the given inputs applied.
  task automatic do_reset(input logic en_v, input logic rdy_v, input logic [1:0] mode_v);
    rst = 1'b1;
    run(2);
    rst      = 1'b0;
    en       = en_v;
    tx_ready = rdy_v;
    mode     = mode_v;
  endtask

  initial begin
    // Reset values and X-freedom
    do_reset(1'b1, 1'b1, MODE_INC);
    check("reset_x", 32'($isunknown({tx_valid, tx_data, tx_chan, frame_done, overrun_cnt,
                                     b_valid, b_data, b_chan, b_done, b_ovr})), 32'd0);
    check("reset_valid", 32'(tx_valid), 32'd0);
    check("reset_data", 32'(tx_data), 32'd0);
    check("reset_ovr", 32'(overrun_cnt), 32'd0);

    // INC, ready high
    run(15);
    check("c15_valid", 32'(tx_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      run(1);
      check("inc_valid", 32'(tx_valid), 32'd1);
      check("inc_data", 32'(tx_data), 32'(k));
      check("inc_chan", 32'(tx_chan), 32'(k));
    end
    run(1);
    check("inc_end_valid", 32'(tx_valid), 32'd0);
    check("inc_done", 32'(frame_done), 32'd1);
    check("inc_hold_data", 32'(tx_data), 32'd3);
    run(1);
    check("inc_done_pulse", 32'(frame_done), 32'd0);
    run(11);
    for (int k = 0; k < 4; k++) begin
      check("inc2_data", 32'(tx_data), 32'(k + 1));
      check("inc2_chan", 32'(tx_chan), 32'(k));
      run(1);
    end

    // Backpressure on channel 1
    do_reset(1'b1, 1'b1, MODE_INC);
    run(17);
    check("bp_chan1", 32'(tx_chan), 32'd1);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run(1);
      check("bp_hold", 32'({tx_valid, tx_chan, tx_data}), 32'({1'b1, 2'd1, 8'd1}));
    end
    tx_ready = 1'b1;
    run(1);
    check("bp_resume2", 32'({tx_chan, tx_data}), 32'({2'd2, 8'd2}));
    run(1);
    check("bp_resume3", 32'({tx_chan, tx_data}), 32'({2'd3, 8'd3}));
    run(1);
    check("bp_done", 32'({tx_valid, frame_done}), 32'({1'b0, 1'b1}));
    check("bp_no_ovr", 32'(overrun_cnt), 32'd0);

    // Overrun, ending with a tick on the final-handshake cycle, then saturation
    do_reset(1'b1, 1'b0, MODE_INC);
    run(16);
    check("ov_start", 32'({tx_valid, tx_data}), 32'({1'b1, 8'd0}));
    run(44);
    check("ov_cnt2", 32'(overrun_cnt), 32'd2);
    check("ov_held", 32'({tx_valid, tx_chan, tx_data}), 32'({1'b1, 2'd0, 8'd0}));
    tx_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      run(1);
      check("ov_resume", 32'({tx_chan, tx_data}), 32'({2'(k), 8'(k)}));
    end
    run(1);
    check("ov_done", 32'({tx_valid, frame_done}), 32'({1'b0, 1'b1}));
    check("ov_last_hs_tick", 32'(overrun_cnt), 32'd3);
    tx_ready = 1'b0;
    run(4200);
    check("ov_saturate", 32'(overrun_cnt), 32'd255);

    // LFSR on channel 0, with a mid-frame mode change
    do_reset(1'b1, 1'b1, MODE_LFSR);
    for (int f = 0; f < 5; f++) begin
      run(16);
      check("lfsr_ch0", 32'({tx_chan, tx_data}), 32'({2'd0, lfsr_exp[f]}));
    end
    run(1);
    check("lfsr_ch1_f4", 32'({tx_chan, tx_data}), 32'({2'd1, 8'h17}));
    mode = MODE_INC;
    run(16);
    check("lfsr_midchange", 32'({tx_chan, tx_data}), 32'({2'd1, 8'hB3}));
    run(16);
    check("lfsr_then_inc", 32'({tx_chan, tx_data}), 32'({2'd1, 8'hB4}));

    // WALK on channel 3
    do_reset(1'b1, 1'b1, MODE_WALK);
    run(19);
    check("walk_f0", 32'({tx_chan, tx_data}), 32'({2'd3, 8'h03}));
    run(16);
    check("walk_f1", 32'({tx_chan, tx_data}), 32'({2'd3, 8'h06}));
    run(16);
    check("walk_f2", 32'({tx_chan, tx_data}), 32'({2'd3, 8'h0C}));

    // en falls mid-frame
    do_reset(1'b1, 1'b1, MODE_INC);
    run(18);
    check("en_chan2", 32'(tx_chan), 32'd2);
    en = 1'b0;
    run(1);
    check("en_finish", 32'({tx_valid, tx_chan, tx_data}), 32'({1'b1, 2'd3, 8'd3}));
    run(1);
    check("en_done", 32'({tx_valid, frame_done}), 32'({1'b0, 1'b1}));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      run(1);
      if (tx_valid !== 1'b0) seen = 1'b1;
    end
    check("en_no_more", 32'(seen), 32'd0);

    // rst mid-frame
    do_reset(1'b1, 1'b1, MODE_INC);
    run(18);
    rst = 1'b1;
    run(1);
    check("rst_mid", 32'({tx_valid, tx_chan, tx_data}), 32'd0);
    rst = 1'b0;
    run(16);
    check("rst_reseed0", 32'({tx_valid, tx_chan, tx_data}), 32'({1'b1, 2'd0, 8'd0}));
    run(1);
    check("rst_reseed1", 32'({tx_chan, tx_data}), 32'({2'd1, 8'd1}));

    // N_CH=1, DATA_W=4: chan stays 0, INC wraps 15->0
    do_reset(1'b1, 1'b1, MODE_INC);
    for (int f = 0; f < 17; f++) begin
      run(16);
      check("n1_word", 32'({b_valid, b_chan, b_data}), 32'({1'b1, 1'b0, 4'(f)}));
    end
    run(1);
    check("n1_done", 32'({b_valid, b_done}), 32'({1'b0, 1'b1}));

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
